// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port indices and the supported synchronous-read latency range.
// Latency: n/a (types and constants only). Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  // Wait counter only ever holds READ_LAT-1.
  localparam int CNT_W = $clog2(READ_LAT_MAX);

  // Port index to one-hot {port1, port0} vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_LDR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Combinational 2-way round-robin picker with per-port request masking.
// Latency: 0 cycles (pure combinational). Backpressure: none, the caller gates the grant.
// Ports: req[1:0] requests, last_gnt = port granted last, mask[1:0] = 1 blocks that port,
//        gnt[1:0] one-hot (or zero) winner.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] w_req;

  assign w_req = req & ~mask;

  always_comb begin
    gnt = w_req;
    // On a tie the port that did not win last time takes it.
    if (&w_req) begin
      gnt = port_onehot(~last_gnt);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU (port 0) and the loader/debug host (port 1).
// Latency from gnt: write done at +2, read done at +2+READ_LAT; next grant the cycle after done.
// Backpressure: no grant while busy; requests simply stay pending until the FSM returns to IDLE.
// Ports: req/we/addr/wdata/lock per requester in, gnt/done one-cycle pulses out, rdata held
//        until the next read completes; Mem* drive the memory; busy = FSM not in IDLE.
// Optional macro MEM_ARB_LOCK_EN: an owner whose lock is high in its RESP cycle keeps
// exclusive ownership until it completes an access with lock low; otherwise lock0/lock1 are ignored.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              MemEn,
  output logic              MemWen,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              busy
);

  // Out-of-range latencies are clamped into the supported window.
  localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  state_t              r_state;
  logic                r_last_gnt;
  logic                r_port;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_en;
  logic                r_mem_wen;
  logic                r_done0;
  logic                r_done1;

  logic [1:0]          w_req;
  logic [1:0]          w_mask;
  logic [1:0]          w_pick;
  logic [1:0]          w_gnt;
  logic                w_idle;
  logic                w_win;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_req = {req1, req0};

`ifdef MEM_ARB_LOCK_EN
  logic r_locked;
  logic r_lock_port;
  logic w_lock_cur;

  assign w_lock_cur = (r_port == PORT_LDR) ? lock1 : lock0;
  // While locked only the owner may win.
  assign w_mask     = r_locked ? ~port_onehot(r_lock_port) : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_locked    <= 1'b0;
      r_lock_port <= PORT_CPU;
    end else if (r_state == RESP) begin
      r_locked    <= w_lock_cur;
      r_lock_port <= r_port;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = lock0 ^ lock1;
  assign w_mask        = 2'b00;
`endif

  mem_arb_rr2 u_rr (
    .req      (w_req),
    .last_gnt (r_last_gnt),
    .mask     (w_mask),
    .gnt      (w_pick)
  );

  // Grant is combinational in IDLE; forced low while reset is asserted so every
  // output reads zero during reset even with requests pending.
  assign w_idle      = (r_state == IDLE);
  assign w_gnt       = w_pick & {2{w_idle & ~reset}};
  assign w_win       = w_gnt[1];
  assign w_sel_we    = (w_win == PORT_LDR) ? we1    : we0;
  assign w_sel_addr  = (w_win == PORT_LDR) ? addr1  : addr0;
  assign w_sel_wdata = (w_win == PORT_LDR) ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= PORT_LDR;
      r_port     <= PORT_CPU;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_port     <= w_win;
            r_last_gnt <= w_win;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_mem_en   <= 1'b1;
            r_mem_wen  <= w_sel_we;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_mem_en  <= 1'b0;
          r_mem_wen <= 1'b0;
          if (r_we) begin
            {r_done1, r_done0} <= port_onehot(r_port);
            r_state            <= RESP;
          end else begin
            r_cnt   <= CNT_W'(LAT - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // Memory data is valid in the last wait cycle; capture it at its end.
          if (r_cnt == '0) begin
            r_rdata            <= MemRdata;
            {r_done1, r_done0} <= port_onehot(r_port);
            r_state            <= RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0     = w_gnt[0];
  assign gnt1     = w_gnt[1];
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign rdata    = r_rdata;
  assign MemEn    = r_mem_en;
  assign MemWen   = r_mem_wen;
  assign MemAddr  = r_addr;
  assign MemWdata = r_wdata;
  assign busy     = ~w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with READ_LAT=1 and one with READ_LAT=3
// share the same requester stimulus; each has its own memory model of matching latency.
// Cycle-table vectors cover write/read latency, then hand sequences cover round-robin, lock and reset.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          gnt0_a, gnt1_a, done0_a, done1_a, MemEn_a, MemWen_a, busy_a;
  logic [AW-1:0] MemAddr_a;
  logic [DW-1:0] MemWdata_a, rdata_a, MemRdata_a;
  logic          gnt0_b, gnt1_b, done0_b, done1_b, MemEn_b, MemWen_b, busy_b;
  logic [AW-1:0] MemAddr_b;
  logic [DW-1:0] MemWdata_b, rdata_b, MemRdata_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0_a), .gnt1(gnt1_a),
    .done0(done0_a), .done1(done1_a), .rdata(rdata_a), .MemEn(MemEn_a),
    .MemWen(MemWen_a), .MemAddr(MemAddr_a), .MemWdata(MemWdata_a),
    .MemRdata(MemRdata_a), .busy(busy_a)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0_b), .gnt1(gnt1_b),
    .done0(done0_b), .done1(done1_b), .rdata(rdata_b), .MemEn(MemEn_b),
    .MemWen(MemWen_b), .MemAddr(MemAddr_b), .MemWdata(MemWdata_b),
    .MemRdata(MemRdata_b), .busy(busy_b)
  );

  // Synchronous memories: latency 1 for instance a, latency 3 for instance b.
  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_b [0:1023];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [0:2];

  always @(posedge clk) begin
    if (MemEn_a && MemWen_a) mem_a[MemAddr_a] <= MemWdata_a;
    if (MemEn_a && !MemWen_a) pipe_a <= mem_a[MemAddr_a];
    if (MemEn_b && MemWen_b) mem_b[MemAddr_b] <= MemWdata_b;
    if (MemEn_b && !MemWen_b) pipe_b[0] <= mem_b[MemAddr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign MemRdata_a = pipe_a;
  assign MemRdata_b = pipe_b[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ctl = {gnt0, gnt1, done0, done1, MemEn, MemWen, busy}; ctl3 = {done0, MemEn, busy} of instance b.
  typedef struct {
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic [6:0]    ctl;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] rdata;
    logic [2:0]    ctl3;
    logic [DW-1:0] rdata3;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [6:0] c,
                              input logic [AW-1:0] ma, input logic [DW-1:0] mw,
                              input logic [DW-1:0] rd, input logic [2:0] c3,
                              input logic [DW-1:0] rd3);
    vec_t v;
    v.req0 = r; v.we0 = w; v.addr0 = a; v.wdata0 = d; v.ctl = c;
    v.maddr = ma; v.mwdata = mw; v.rdata = rd; v.ctl3 = c3; v.rdata3 = rd3;
    return v;
  endfunction

  task automatic pulse_reset();
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  localparam logic [DW-1:0] D = 32'hDEADBEEF;
  localparam int NV = 11;

  vec_t tv [NV];
  int   n_g0, n_g1, n_d1;
  int   gport [$];
  int   gcyc  [$];
  int   exp_port [4];
  logic [1:0] eg, ed;

  initial begin
    // Cycle 0 is the grant cycle of a CPU write; cycle 4 the grant of a CPU read.
    tv[0]  = mk(1'b1, 1'b1, 10'h005, D,            7'b1000000, 10'h000, 32'h0, 32'h0, 3'b000, 32'h0);
    tv[1]  = mk(1'b0, 1'b1, 10'h3FF, 32'h12345678, 7'b0000111, 10'h005, D,     32'h0, 3'b011, 32'h0);
    tv[2]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        7'b0010001, 10'h005, D,     32'h0, 3'b101, 32'h0);
    tv[3]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        7'b0000000, 10'h005, D,     32'h0, 3'b000, 32'h0);
    tv[4]  = mk(1'b1, 1'b0, 10'h005, 32'h0,        7'b1000000, 10'h005, D,     32'h0, 3'b000, 32'h0);
    tv[5]  = mk(1'b0, 1'b0, 10'h3FF, 32'h0,        7'b0000101, 10'h005, 32'h0, 32'h0, 3'b011, 32'h0);
    tv[6]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        7'b0000001, 10'h005, 32'h0, 32'h0, 3'b001, 32'h0);
    tv[7]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        7'b0010001, 10'h005, 32'h0, D,     3'b001, 32'h0);
    tv[8]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        7'b0000000, 10'h005, 32'h0, D,     3'b001, 32'h0);
    tv[9]  = mk(1'b0, 1'b0, 10'h000, 32'h0,        7'b0000000, 10'h005, 32'h0, D,     3'b101, D);
    tv[10] = mk(1'b0, 1'b0, 10'h000, 32'h0,        7'b0000000, 10'h005, 32'h0, D,     3'b000, D);

`ifdef MEM_ARB_LOCK_EN
    exp_port = '{1, 1, 1, 0};
`else
    exp_port = '{1, 0, 1, 1};
`endif

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state, including a pending request that must not be granted.
    @(negedge clk);
    chk("rst_ctl_a", 64'({gnt0_a, gnt1_a, done0_a, done1_a, MemEn_a, MemWen_a, busy_a, MemAddr_a}), 64'h0);
    chk("rst_data_a", 64'({MemWdata_a, rdata_a}), 64'h0);
    chk("rst_ctl_b", 64'({gnt0_b, gnt1_b, done0_b, done1_b, MemEn_b, MemWen_b, busy_b, MemAddr_b}), 64'h0);
    req0 = 1'b1;
    #1;
    chk("rst_gnt_gate", 64'({gnt0_a, gnt1_a}), 64'h0);
    req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Table: CPU write then CPU read of the same word.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      req0 = tv[i].req0; we0 = tv[i].we0; addr0 = tv[i].addr0; wdata0 = tv[i].wdata0;
      @(negedge clk);
      chk($sformatf("v%0d_ctl", i),
          64'({gnt0_a, gnt1_a, done0_a, done1_a, MemEn_a, MemWen_a, busy_a}), 64'(tv[i].ctl));
      chk($sformatf("v%0d_maddr", i), 64'(MemAddr_a), 64'(tv[i].maddr));
      chk($sformatf("v%0d_mwdata", i), 64'(MemWdata_a), 64'(tv[i].mwdata));
      chk($sformatf("v%0d_rdata", i), 64'(rdata_a), 64'(tv[i].rdata));
      chk($sformatf("v%0d_ctl3", i), 64'({done0_b, MemEn_b, busy_b}), 64'(tv[i].ctl3));
      chk($sformatf("v%0d_rdata3", i), 64'(rdata_b), 64'(tv[i].rdata3));
    end

    // Round-robin: both ports write continuously from reset; grants every 3 cycles, port 0 first.
    pulse_reset();
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      addr0 = 10'h010; addr1 = 10'h020; wdata0 = 32'(k); wdata1 = 32'(k);
      @(negedge clk);
      eg = (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      ed = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("rr%0d_gnt_a", k), 64'({gnt1_a, gnt0_a}), 64'(eg));
      chk($sformatf("rr%0d_done_a", k), 64'({done1_a, done0_a}), 64'(ed));
      chk($sformatf("rr%0d_gnt_b", k), 64'({gnt1_b, gnt0_b}), 64'(eg));
      chk($sformatf("rr%0d_done_b", k), 64'({done1_b, done0_b}), 64'(ed));
    end

    // Loader burst of three writes (lock 1,1,0) while the CPU waits from cycle 1.
    pulse_reset();
    n_g0 = 0; n_g1 = 0; n_d1 = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      req0 = (k >= 1) && (n_g0 < 1); we0 = 1'b1; addr0 = 10'h030; wdata0 = 32'h0000C0DE;
      req1 = (n_g1 < 3); we1 = 1'b1; addr1 = 10'h040 + 10'(n_g1); wdata1 = 32'(n_g1);
      lock1 = (n_d1 < 2); lock0 = 1'b0;
      @(negedge clk);
      if (gnt0_a) begin n_g0++; gport.push_back(0); gcyc.push_back(k); end
      if (gnt1_a) begin n_g1++; gport.push_back(1); gcyc.push_back(k); end
      if (done1_a) n_d1++;
    end
    chk("lock_ngnt", 64'(gport.size()), 64'd4);
    for (int i = 0; i < 4 && i < gport.size(); i++) begin
      chk($sformatf("lock_port%0d", i), 64'(gport[i]), 64'(exp_port[i]));
      chk($sformatf("lock_cyc%0d", i), 64'(gcyc[i]), 64'(3 * i));
    end

    // Loader read of 0x005 so rdata is non-zero before the reset test.
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h005; wdata1 = 32'hCAFE0001;
    @(negedge clk);
    chk("ldr_rd_gnt", 64'({gnt1_a, gnt0_a, gnt1_b, gnt0_b}), 64'b1010);
    @(posedge clk); #1;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ldr_rd_done_a", 64'({done1_a, done0_a}), 64'b10);
    chk("ldr_rd_data_a", 64'(rdata_a), 64'(D));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ldr_rd_done_b", 64'({done1_b, done0_b}), 64'b10);
    chk("ldr_rd_data_b", 64'(rdata_b), 64'(D));
    repeat (2) @(posedge clk);

    // Loader read of 0x123 aborted by reset in its first WAIT cycle.
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h123; wdata1 = 32'hCAFE0002;
    @(negedge clk);
    chk("abort_gnt", 64'({gnt1_a, gnt0_a}), 64'b10);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    chk("abort_issue", 64'({MemEn_a, MemWen_a, MemAddr_a}), 64'({1'b1, 1'b0, 10'h123}));
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h050; wdata0 = 32'h0BADF00D;
    req1 = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("abort_ctl_a", 64'({gnt0_a, gnt1_a, done0_a, done1_a, MemEn_a, MemWen_a, busy_a, MemAddr_a}), 64'h0);
    chk("abort_data_a", 64'({MemWdata_a, rdata_a}), 64'h0);
    chk("abort_ctl_b", 64'({gnt0_b, gnt1_b, done0_b, done1_b, MemEn_b, MemWen_b, busy_b, MemAddr_b}), 64'h0);
    chk("abort_data_b", 64'({MemWdata_b, rdata_b}), 64'h0);
    @(posedge clk); #1;
    chk("abort_hold", 64'({done1_a, done1_b, busy_a, busy_b}), 64'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_gnt_a", 64'({gnt1_a, gnt0_a}), 64'b01);
    chk("post_rst_gnt_b", 64'({gnt1_b, gnt0_b}), 64'b01);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("post_rst_issue", 64'({MemEn_a, MemWen_a, MemAddr_a}), 64'({1'b1, 1'b1, 10'h050}));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("no_done1_%0d", k), 64'({done1_a, done1_b}), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port data/instruction memory between two requesters: port 0 is the CPU control/datapath (fetch, LOAD, STORE), and port 1 is the program loader/debug host. The block arbitrates with 2-way round-robin and sequences each memory access through a fixed FSM. It returns a one-cycle done pulse, so requesters see a uniform req/gnt/done handshake regardless of memory read latency.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, memory data width
READ_LAT, 1, synchronous memory read latency in cycles (legal range 1..4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0, req1  in  1 each  access request, port 0 (CPU) / port 1 (loader)
we0, we1  in  1 each  1 = write, 0 = read
addr0, addr1  in  ADDR_W each  word address
wdata0, wdata1  in  DATA_W each  write data
lock0, lock1  in  1 each  hold ownership after completion (used only with the optional feature)
gnt0, gnt1  out  1 each  one-cycle pulse; request accepted
done0, done1  out  1 each  one-cycle pulse; access complete
rdata  out  DATA_W  last read data; valid in the done cycle, held until the next read completes
MemEn  out  1  memory enable
MemWen  out  1  memory write enable
MemAddr  out  ADDR_W  memory address
MemWdata  out  DATA_W  memory write data
MemRdata  in  DATA_W  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (asynchronous): state = IDLE; last_gnt = 1, so port 0 wins the first tie; every output is 0, including rdata, MemAddr and MemWdata; the wait counter is 0.
- Reset asserted mid-access: the access is aborted; MemEn/MemWen drop immediately; no done pulse is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner is chosen combinationally among the asserted reqs.
  - If both ports request, the winner is the port != last_gnt.
  - gnt of the winner is asserted in this same cycle.
  - At the clock edge, the winner's we/addr/wdata and the port index are latched, last_gnt is updated, and next state = ISSUE.
  - If no req is asserted, the FSM stays in IDLE.
- ISSUE (exactly 1 cycle):
  - MemEn = 1, MemWen = latched we, MemAddr/MemWdata driven from the latched copies.
  - Write: next state = RESP.
  - Read: next state = WAIT, counter loaded with READ_LAT-1.
- WAIT:
  - MemEn = 0; MemAddr is held.
  - Lasts READ_LAT cycles; the counter decrements each cycle.
  - In the cycle where counter == 0, MemRdata is sampled into rdata at the edge and next state = RESP.
- RESP (1 cycle): done of the latched port = 1; next state = IDLE.
- Latency from the gnt cycle:
  - Write: MemEn at +1, done at +2, next grant possible at +3.
  - Read: MemEn at +1, done at +2+READ_LAT.
- Requester rules:
  - req/we/addr/wdata must be held stable until gnt is seen.
  - Values after gnt are ignored.
  - A req dropped before gnt is not served.
  - A req held through done is treated as a new request when the FSM returns to IDLE.
- No grant is issued while busy; reqs are simply left pending.
- gnt0 and gnt1 are never asserted together; done0 and done1 are never asserted together.

Optional Feature:
MEM_ARB_LOCK_EN
- Defined:
  - If the owning port's lock is high in its RESP cycle, the arbiter enters a locked mode.
  - In locked mode, IDLE grants only that port; the other port's req is masked.
  - The lock is released when the owner completes an access with lock = 0, or on reset.
  - Intended for loader bursts and read-modify-write sequences.
- Undefined: lock0/lock1 are ignored and pure round-robin applies.
- The ports exist in both builds.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10, RESP = 2'b11), port index constants PORT_CPU = 0 and PORT_LDR = 1, and the READ_LAT legal-range limit.
- One sub-module, mem_arb_rr2: a combinational 2-way round-robin picker with inputs req[1:0], last_gnt and mask[1:0], and output a one-hot grant.

Test Plan:
- Single CPU write, addr0 = 0x005, wdata0 = 0xDEADBEEF -> gnt0 at cycle 0; MemEn = MemWen = 1 with MemAddr = 0x005 at cycle 1; done0 at cycle 2; busy low at cycle 3.
- Read of 0x005 with READ_LAT = 1, then READ_LAT = 3 -> done0 at cycle 3 and cycle 5 respectively, rdata = 0xDEADBEEF; MemEn high only in cycle 1.
- req0 and req1 held continuously after reset -> grants alternate 0, 1, 0, 1; the first grant goes to port 0; no cycle has both gnts or both dones.
- reset pulsed during WAIT of a port 1 read -> MemEn = 0 and all outputs 0 immediately; no done1; after release, a pending req0 is granted first.
- MEM_ARB_LOCK_EN defined: port 1 performs 3 writes with lock1 = 1, 1, 0 while req0 is held -> the 3 port 1 accesses are served back-to-back, then gnt0; without the macro, the grants interleave.
